// File: rtl/dsm_cic_decimator.sv
// CIC decimator for a 1-bit delta-sigma bitstream: ORDER integrators at the bit rate, ORDER
// combs at the frame rate, then scaling and saturation to a signed OUT_W-bit sample.
module dsm_cic_decimator #(
    parameter int unsigned ORDER = 3,
    parameter int unsigned DECIM = 64,
    parameter int unsigned OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bit_in,
    input  logic                    bit_en,
    output logic signed [OUT_W-1:0] sample_out,
    output logic                    sample_valid,
    output logic                    settled
);

    localparam int unsigned LOG2R  = $clog2(DECIM);
    localparam int unsigned ACC_W  = 2 + ORDER * LOG2R;
    localparam int unsigned CNT_W  = LOG2R;
    localparam int unsigned WARM_W = $clog2(ORDER + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(ORDER);

    logic signed [ACC_W-1:0] integ_q [ORDER];
    logic signed [ACC_W-1:0] integ_d [ORDER];
    logic signed [ACC_W-1:0] dly_q   [ORDER];
    logic signed [ACC_W-1:0] dly_d   [ORDER];
    // Only the top OUT_W+1 bits of the comb result survive the arithmetic shift.
    logic signed [OUT_W:0]   comb_q, comb_d;
    logic                    comb_vld_q, comb_vld_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    dec_stb_q, dec_stb_d;
    logic [WARM_W-1:0]       warm_q, warm_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic                    valid_q, valid_d;
    logic                    settled_q, settled_d;
    logic signed [OUT_W-1:0] sat_val;

    // Integrator cascade ripples within one cycle so I_ORDER includes the bit just accepted.
    always_comb begin : integ_comb
        logic signed [ACC_W-1:0] acc;
        integ_d = integ_q;
        acc     = {{(ACC_W-1){~bit_in}}, 1'b1};
        if (bit_en) begin
            for (int k = 0; k < ORDER; k++) begin
                acc        = integ_q[k] + acc;
                integ_d[k] = acc;
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        dec_stb_d = 1'b0;
        if (bit_en) begin
            cnt_d     = cnt_q + 1'b1;
            dec_stb_d = (cnt_q == CNT_LAST);
        end
    end

    always_comb begin : comb_chain
        logic signed [ACC_W-1:0] acc;
        dly_d      = dly_q;
        comb_d     = comb_q;
        comb_vld_d = dec_stb_q;
        acc        = integ_q[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            if (dec_stb_q) begin
                dly_d[k] = acc;
            end
            acc = acc - dly_q[k];
        end
        if (dec_stb_q) begin
            comb_d = acc[ACC_W-1 -: OUT_W+1];
        end
    end

    always_comb begin
        if (comb_q[OUT_W] != comb_q[OUT_W-1]) begin
            sat_val = comb_q[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            sat_val = comb_q[OUT_W-1:0];
        end
    end

    // The first ORDER frame results carry start-up transients and are dropped.
    always_comb begin
        out_d     = out_q;
        valid_d   = 1'b0;
        settled_d = settled_q;
        warm_d    = warm_q;
        if (comb_vld_q) begin
            if (warm_q != WARM_MAX) begin
                warm_d = warm_q + 1'b1;
            end else begin
                out_d     = sat_val;
                valid_d   = 1'b1;
                settled_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            comb_q     <= '0;
            comb_vld_q <= 1'b0;
            cnt_q      <= '0;
            dec_stb_q  <= 1'b0;
            warm_q     <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            settled_q  <= 1'b0;
        end else begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
                dly_q[k]   <= dly_d[k];
            end
            comb_q     <= comb_d;
            comb_vld_q <= comb_vld_d;
            cnt_q      <= cnt_d;
            dec_stb_q  <= dec_stb_d;
            warm_q     <= warm_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            settled_q  <= settled_d;
        end
    end

    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign settled      = settled_q;

endmodule

// File: tb/tb_dsm_cic_decimator.sv
// Scoreboard bench: a convolution model of the CIC (boxcar^ORDER impulse response) predicts
// every decimated sample and its cycle; a negedge monitor compares whatever the DUT presents.
module tb_dsm_cic_decimator;

    localparam int ORDER = 3;
    localparam int DECIM = 64;
    localparam int OUT_W = 16;
    localparam int SHIFT = ORDER * $clog2(DECIM) - (OUT_W - 1);
    localparam int HL    = ORDER * (DECIM - 1) + 1;
    localparam int BIG   = 32'h7fff_ffff;
    localparam int MAXV  = (1 << (OUT_W - 1)) - 1;
    localparam int MINV  = -(1 << (OUT_W - 1));

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic                    bit_in;
    logic                    bit_en;
    logic signed [OUT_W-1:0] sample_out;
    logic                    sample_valid;
    logic                    settled;

    int   total;
    int   bad;
    int   cyc;
    int   rst_cyc;
    int   settle_cyc;
    int   h [HL];
    int   hist [$];
    exp_t expq [$];

    dsm_cic_decimator #(
        .ORDER(ORDER),
        .DECIM(DECIM),
        .OUT_W(OUT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_en      (bit_en),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .settled     (settled)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int floor_div(input int y, input int d);
        if (y >= 0) return y / d;
        return -((-y + d - 1) / d);
    endfunction

    function automatic int saturate(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    // Reference model: output of frame k = sum_j h[j] * x[n-j], n = last bit of frame k.
    initial begin
        int tmp [HL];
        int len;
        int s;
        int n;
        int y;
        int frame;
        cyc        = 0;
        rst_cyc    = -1;
        settle_cyc = BIG;
        for (int i = 0; i < HL; i++) h[i] = 0;
        h[0] = 1;
        len  = 1;
        for (int st = 0; st < ORDER; st++) begin
            for (int i = 0; i < len + DECIM - 1; i++) begin
                s = 0;
                for (int j = 0; j < DECIM; j++) begin
                    if (i - j >= 0 && i - j < len) s += h[i-j];
                end
                tmp[i] = s;
            end
            len = len + DECIM - 1;
            for (int i = 0; i < len; i++) h[i] = tmp[i];
        end
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                hist.delete();
                expq.delete();
                rst_cyc    = cyc;
                settle_cyc = BIG;
            end else if (bit_en) begin
                hist.push_back(bit_in ? 1 : -1);
                if (hist.size() % DECIM == 0) begin
                    frame = hist.size() / DECIM;
                    n     = hist.size() - 1;
                    y     = 0;
                    for (int j = 0; j < HL; j++) begin
                        if (n - j >= 0) y += h[j] * hist[n-j];
                    end
                    if (frame > ORDER) begin
                        expq.push_back('{cyc + 2, saturate(floor_div(y, 1 << SHIFT))});
                        if (frame == ORDER + 1) settle_cyc = cyc + 2;
                    end
                end
            end
        end
    end

    // Monitor: pulses, their timing and value, held output and settled flag.
    initial begin
        int   last_val;
        exp_t e;
        last_val = 0;
        forever begin
            @(negedge clk);
            if (cyc == rst_cyc) begin
                last_val = 0;
                check("reset_valid", int'(sample_valid), 0);
            end
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missed_pulse: got none, expected value %0d at cycle %0d",
                         expq[0].val, expq[0].cyc);
                void'(expq.pop_front());
            end
            if (sample_valid) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: got value %0d, expected no pulse (cycle %0d)",
                             sample_out, cyc);
                end else begin
                    e = expq.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_value", int'(sample_out), e.val);
                    last_val = e.val;
                end
            end
            check("held_value", int'(sample_out), last_val);
            check("settled", int'(settled), (cyc >= settle_cyc) ? 1 : 0);
        end
    end

    function automatic logic pat_bit(input int mode, input int b);
        case (mode)
            0:       return 1'b1;
            1:       return (b % 2 == 0);
            2:       return 1'b0;
            3:       return (b % 4 != 3);
            4:       return (b % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // gap: 1 = every cycle, 3 = one cycle in three, otherwise random ~70% duty.
    task automatic drive(input int mode, input int nbits, input int gap);
        int  b;
        int  c;
        logic en;
        b = 0;
        c = 0;
        while (b < nbits) begin
            @(negedge clk);
            if (gap == 1) en = 1'b1;
            else if (gap == 3) en = (c % 3 == 0);
            else en = ($urandom_range(0, 9) < 7);
            c++;
            bit_en = en;
            bit_in = en ? pat_bit(mode, b) : 1'($urandom_range(0, 1));
            if (en) b++;
        end
        @(negedge clk);
        bit_en = 1'b0;
        bit_in = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_en = 1'b0;
            bit_in = 1'($urandom_range(0, 1));
        end
    endtask

    // Ends on the negedge following the last reset edge; bit_en is high to show reset wins.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst    = 1'b1;
        bit_en = 1'b1;
        bit_in = 1'b1;
        repeat (n) @(negedge clk);
        rst    = 1'b0;
        bit_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        bit_en = 1'b0;
        bit_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", int'(sample_out), 0);
        check("rst_settled", int'(settled), 0);
        rst = 1'b0;

        drive(0, 5 * DECIM, 1);
        idle(4);
        check("ones_out", int'(sample_out), 32767);
        check("ones_settled", int'(settled), 1);

        do_reset(2);
        drive(1, 5 * DECIM, 1);
        idle(4);
        check("alt_out", int'(sample_out), 0);

        do_reset(1);
        drive(2, 5 * DECIM, 1);
        idle(4);
        check("zeros_out", int'(sample_out), -32768);

        do_reset(1);
        drive(3, 5 * DECIM, 1);
        idle(4);
        check("p1110_out", int'(sample_out), 16384);
        drive(4, 5 * DECIM, 1);
        idle(4);
        check("p0001_out", int'(sample_out), -16384);

        do_reset(1);
        drive(3, 5 * DECIM, 3);
        idle(4);
        check("gap3_out", int'(sample_out), 16384);

        drive(3, 30, 1);
        do_reset(1);
        check("midrst_out", int'(sample_out), 0);
        check("midrst_valid", int'(sample_valid), 0);
        check("midrst_settled", int'(settled), 0);

        drive(5, 6 * DECIM, 0);
        idle(4);
        drive(5, 8 * DECIM, 1);
        idle(8);
        check("queue_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
